// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and core-side adapters.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;

  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the core's MEM stage: one outstanding request,
// configurable wait states, byte-lane stores, misalign/range error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_error_q;
  logic        rsp_load_q;

  logic        accept;
  logic        access_now;
  logic        a_write;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic [31:0] a_offset;
  logic        a_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0] ram_rdata;

  assign accept = req_valid && req_ready_q && (state_q == IDLE);

  // With zero wait states the access is issued on the accept edge itself,
  // so the RAM is fed straight from the request inputs while in IDLE.
  always_comb begin
    a_write = write_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_wstrb = wstrb_q;
    if (state_q == IDLE) begin
      a_write = req_write;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_wstrb = req_wstrb;
    end
  end

  assign access_now = (WAIT_STATES == 0) ? accept
                                         : ((state_q == WAIT) && (cnt_q == '0));
  assign a_offset   = a_addr - BASE_ADDR;
  assign a_err      = (a_addr[1:0] != 2'b00) || (a_offset >= SPAN);
  assign ram_en     = access_now && !a_err;
  assign ram_we     = (ram_en && a_write) ? a_wstrb : '0;
  assign ram_addr   = IDX_W'(word_index(a_addr, BASE_ADDR));

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clock),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(a_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            req_ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= a_err;
              rsp_load_q  <= !a_write && !a_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= a_err;
            rsp_load_q  <= !a_write && !a_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_load_q  <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_load_q ? ram_rdata : '0;

endmodule
